// File: rtl/dig_pkg.sv
// Shared definitions for the display-ownership controller and the bus decoder.
package dig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DBG     = 2'd1,
        RESTORE = 2'd2
    } dig_own_e;

    localparam logic [31:0] DIG_ADDR_DEFAULT = 32'hFFFF_F000;

endpackage

// File: rtl/dig_hold_timer.sv
// Debug hold timer: start clears and arms it; done pulses once when the
// count reaches HOLD_CYCLES-1, after which the timer idles until restarted.
module dig_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic          run_q;

    assign done = run_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (done) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/dig_share_ctrl.sv
// Arbitrates the display write port between CPU stores and debug snapshots,
// shadowing CPU stores while debug holds the display and restoring afterwards.
module dig_share_ctrl
    import dig_pkg::*;
#(
    parameter logic [31:0] DIG_ADDR    = DIG_ADDR_DEFAULT,
    parameter int unsigned HOLD_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    output logic        dbg_gnt,
    output logic        dbg_active,
    output logic        dig_we,
    output logic [31:0] dig_wdata
);

    dig_own_e    state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic        dig_we_d, dbg_gnt_d;
    logic [31:0] dig_wdata_d;
    logic        cpu_hit, hold_start, hold_done;

    assign cpu_hit    = cpu_we && (cpu_addr == DIG_ADDR);
    assign hold_start = dbg_req && !rst;

    dig_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .start (hold_start),
        .done  (hold_done)
    );

    always_comb begin
        state_d     = state_q;
        dig_we_d    = 1'b0;
        dig_wdata_d = dig_wdata;
        dbg_gnt_d   = 1'b0;
        shadow_d    = cpu_hit ? cpu_wdata : shadow_q;

        // A debug request wins in every state, including a simultaneous CPU hit.
        if (dbg_req) begin
            state_d     = DBG;
            dig_we_d    = 1'b1;
            dig_wdata_d = dbg_data;
            dbg_gnt_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_hit) begin
                        dig_we_d    = 1'b1;
                        dig_wdata_d = cpu_wdata;
                    end
                end
                DBG: begin
                    if (hold_done) begin
                        state_d = RESTORE;
                    end
                end
                RESTORE: begin
                    state_d     = IDLE;
                    dig_we_d    = 1'b1;
                    dig_wdata_d = cpu_hit ? cpu_wdata : shadow_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            dig_we     <= 1'b0;
            dig_wdata  <= '0;
            dbg_gnt    <= 1'b0;
            dbg_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            dig_we     <= dig_we_d;
            dig_wdata  <= dig_wdata_d;
            dbg_gnt    <= dbg_gnt_d;
            dbg_active <= (state_d == DBG);
        end
    end

endmodule

// File: tb/tb_dig_share_ctrl.sv
// Bench for dig_share_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a countdown-based ownership model.
module tb_dig_share_ctrl;

    localparam int unsigned HOLD = 8;
    localparam logic [31:0] ADDR = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_data = '0;
    logic        dbg_gnt, dbg_active, dig_we;
    logic [31:0] dig_wdata;

    always #5 clk = ~clk;

    dig_share_ctrl #(
        .DIG_ADDR    (ADDR),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .dbg_req    (dbg_req),
        .dbg_data   (dbg_data),
        .dbg_gnt    (dbg_gnt),
        .dbg_active (dbg_active),
        .dig_we     (dig_we),
        .dig_wdata  (dig_wdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: debug ownership as a countdown of remaining cycles.
    logic        m_we = 1'b0, m_gnt = 1'b0, m_active = 1'b0, m_restore = 1'b0;
    logic [31:0] m_wdata = '0, m_shadow = '0;
    int          m_left = 0;

    task automatic model_edge();
        logic hit;
        hit = cpu_we && (cpu_addr == ADDR);
        m_gnt = 1'b0;
        m_we  = 1'b0;
        if (rst) begin
            m_wdata = '0; m_left = 0; m_restore = 1'b0; m_shadow = '0;
        end else begin
            if (dbg_req) begin
                m_we = 1'b1; m_wdata = dbg_data; m_gnt = 1'b1;
                m_left = HOLD; m_restore = 1'b0;
            end else if (m_restore) begin
                m_we = 1'b1; m_wdata = hit ? cpu_wdata : m_shadow;
                m_restore = 1'b0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_restore = 1'b1;
            end else if (hit) begin
                m_we = 1'b1; m_wdata = cpu_wdata;
            end
            if (hit) m_shadow = cpu_wdata;
        end
        m_active = (m_left > 0);
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic q, input logic [31:0] dd);
        rst = r; cpu_addr = a; cpu_we = w; cpu_wdata = d; dbg_req = q; dbg_data = dd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [31:0] wd,
                              input logic gnt, input logic act, input logic chk_wd);
        check({tag, ".dig_we"}, {31'b0, dig_we}, {31'b0, we});
        check({tag, ".dbg_gnt"}, {31'b0, dbg_gnt}, {31'b0, gnt});
        check({tag, ".dbg_active"}, {31'b0, dbg_active}, {31'b0, act});
        if (chk_wd) check({tag, ".dig_wdata"}, dig_wdata, wd);
    endtask

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        q;
        logic [31:0] dd;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_gnt;
        logic        e_act;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, ADDR, 1'b1, 32'h5, 1'b1, 32'h6, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, ADDR, 1'b1, 32'h1234_5678, 1'b0, 32'h0,
                     1'b1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFF_F004, 1'b1, 32'h99, 1'b0, 32'h0,
                     1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, ADDR, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0,
                     1'b1, 32'hAAAA_0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF,
                     1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, ADDR, 1'b1, 32'h0000_00C3, 1'b0, 32'h0,
                     1'b0, 32'h0, 1'b0, 1'b1};
        for (int i = 7; i <= 12; i++)
            vecs[i] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                     1'b1, 32'h0000_00C3, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};

        // Directed table: reset, CPU write, debug hold and restore.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].q, vecs[i].dd);
            expect_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wd, vecs[i].e_gnt,
                       vecs[i].e_act, vecs[i].e_we || vecs[i].r);
        end

        // Simultaneous CPU hit and request: display gets 22, restore writes 11.
        drive(1'b0, ADDR, 1'b1, 32'h11, 1'b1, 32'h22);
        expect_out("simul.grant", 1'b1, 32'h22, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            idle();
            expect_out("simul.hold", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        idle();
        expect_out("simul.restore_cycle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        expect_out("simul.restore", 1'b1, 32'h11, 1'b0, 1'b0, 1'b1);

        // CPU hit during the RESTORE cycle wins over the shadow.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h55);
        expect_out("rcpu.grant", 1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) idle();
        expect_out("rcpu.restore_cycle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, ADDR, 1'b1, 32'h33, 1'b0, 32'h0);
        expect_out("rcpu.restore", 1'b1, 32'h33, 1'b0, 1'b0, 1'b1);

        // Re-request at hold cycle 5 extends ownership by a full period.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1111);
        expect_out("rereq.first", 1'b1, 32'h1111, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBEEF);
        expect_out("rereq.second", 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            idle();
            expect_out("rereq.hold", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        idle();
        expect_out("rereq.restore_cycle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle();
        expect_out("rereq.restore", 1'b1, 32'h33, 1'b0, 1'b0, 1'b1);

        // Reset at hold cycle 3 drops the pending restore.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h77);
        idle();
        idle();
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("midrst.reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < HOLD + 2; i++) begin
            idle();
            expect_out("midrst.quiet", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, ADDR, 1'b1, 32'h44, 1'b0, 32'h0);
        expect_out("midrst.cpu", 1'b1, 32'h44, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, w, q;
            logic [31:0] a;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 3) != 0) ? ADDR : (ADDR + 32'h4);
            drive(r, a, w, $urandom, q, $urandom);
            expect_out("rand", m_we, m_wdata, m_gnt, m_active, m_we || r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
